// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer.
//   - state_t     : handshake FSM states (IDLE/REQ/ACK1/ACK2)
//   - NUM_IR      : number of interrupt request lines
//   - BASE_W/LEVEL_W : vector byte split, {base[4:0], level[2:0]}
//   - level_onehot : level index to one-hot IR mask
//   - make_vector  : assemble the vector byte placed on the data bus
package interrupt_ack_sequencer_pkg;

  localparam int NUM_IR  = 8;
  localparam int BASE_W  = 5;
  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;

  function automatic logic [NUM_IR-1:0] level_onehot(input logic [LEVEL_W-1:0] lvl);
    return NUM_IR'(1) << lvl;
  endfunction

  function automatic logic [7:0] make_vector(input logic [BASE_W-1:0] base,
                                             input logic [LEVEL_W-1:0] lvl);
    return {base, lvl};
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Fixed-priority resolver, IR0 highest.
// Ports:
//   pend  in  8 : candidate request bits
//   isr   in  8 : in-service bits; only pend bits of strictly higher priority
//                 than the lowest-index set isr bit are eligible
//   valid out 1 : some pend bit is eligible
//   level out 3 : index of the lowest-index eligible bit (0 when !valid)
// Passing isr=0 turns this into a plain lowest-set-bit finder on pend.
module interrupt_ack_sequencer_priority_resolver
  import interrupt_ack_sequencer_pkg::*;
(
  input  logic [NUM_IR-1:0]  pend,
  input  logic [NUM_IR-1:0]  isr,
  output logic               valid,
  output logic [LEVEL_W-1:0] level
);

  logic [NUM_IR-1:0] allow;
  logic [NUM_IR-1:0] elig;
  logic              blocked;

  // allow[i] stays set until the first in-service bit is reached; that bit
  // and everything of lower priority is blocked (fully nested mode).
  always_comb begin
    allow   = '0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_IR; i++) begin
      if (isr[i]) blocked = 1'b1;
      allow[i] = ~blocked;
    end
    elig = pend & allow;
  end

  always_comb begin
    valid = 1'b0;
    level = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (elig[i]) begin
        valid = 1'b1;
        level = LEVEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// CPU-facing end of an 8259A-style interrupt controller.
// Raises int_out for the highest-priority unmasked request not blocked by the
// in-service register, runs the two-pulse INTA handshake, drives the vector on
// the second pulse and maintains the ISR (fully nested, non-specific EOI and
// auto-EOI).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   irr, imr        : request latch contents and mask (1 = masked)
//   vector_base     : vector bits T7..T3
//   aeoi            : clear the in-service bit at the end of the handshake
//   eoi_nonspec     : one-cycle pulse, clear lowest-index ISR bit
//   inta_n          : asynchronous CPU acknowledge, active low
//   int_out         : interrupt request to the CPU
//   irr_clear       : one-cycle one-hot clear of the acknowledged IRR bit
//   isr             : in-service register
//   data_out/data_oe: vector byte and its bus drive enable
//   state_dbg       : current handshake state (state_t encoding)
//
// INTA handshake: int_out is held from entry into REQ until the first
// synchronized inta_n fall, which commits the acknowledged level (or flags a
// spurious acknowledge when nothing is eligible). The first low pulse never
// drives the bus; the second low pulse drives {vector_base, level} for exactly
// the synchronized low phase, and its rising edge ends the cycle. Edges of
// inta_n act SYNC_STAGES+1 clocks after the pin moves. SYNC_STAGES must be >= 2.
module interrupt_ack_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       eoi_nonspec,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] irr_clear,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [1:0] state_dbg
);

  import interrupt_ack_sequencer_pkg::*;

  // ---------------- inta_n synchronizer and edge detect ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   inta_fall;
  logic                   inta_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign inta_fall = edge_q & ~sync_q[SYNC_STAGES-1];
  assign inta_rise = ~edge_q & sync_q[SYNC_STAGES-1];

  // ---------------- priority resolution ----------------
  logic [NUM_IR-1:0]  isr_q;
  logic [NUM_IR-1:0]  pend;
  logic               req_valid;
  logic [LEVEL_W-1:0] req_level;
  logic               eoi_valid;
  logic [LEVEL_W-1:0] eoi_level;

  assign pend = irr & ~imr;

  interrupt_ack_sequencer_priority_resolver u_req_resolver (
    .pend  (pend),
    .isr   (isr_q),
    .valid (req_valid),
    .level (req_level)
  );

  // Lowest set ISR bit = the interrupt a non-specific EOI retires.
  interrupt_ack_sequencer_priority_resolver u_eoi_resolver (
    .pend  (isr_q),
    .isr   ({NUM_IR{1'b0}}),
    .valid (eoi_valid),
    .level (eoi_level)
  );

  // ---------------- FSM ----------------
  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_REQ;
      ST_REQ:  if (inta_fall) state_d = ST_ACK1;
      ST_ACK1: if (inta_rise) state_d = ST_ACK2;
      ST_ACK2: if (inta_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic ack_take;
  logic vec_drive;
  logic ack_done;

  always_comb begin
    ack_take  = (state_q == ST_REQ)  && inta_fall;
    vec_drive = (state_q == ST_ACK2) && inta_fall;
    ack_done  = (state_q == ST_ACK2) && inta_rise;
  end

  // ---------------- datapath ----------------
  logic [LEVEL_W-1:0] level_q;
  logic               spurious_q;
  logic [NUM_IR-1:0]  irr_clear_q;
  logic [7:0]         data_out_q;
  logic               drive_q;
  logic [NUM_IR-1:0]  isr_set;
  logic [NUM_IR-1:0]  isr_clr;

  // Set and clear never hit the same bit: a newly acknowledged level is
  // always of higher priority than any bit already in service.
  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    if (ack_take && req_valid)
      isr_set = level_onehot(req_level);
    if (eoi_nonspec && eoi_valid)
      isr_clr = isr_clr | level_onehot(eoi_level);
    if (ack_done && aeoi && !spurious_q)
      isr_clr = isr_clr | level_onehot(level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      spurious_q  <= 1'b0;
      isr_q       <= '0;
      irr_clear_q <= '0;
      data_out_q  <= '0;
      drive_q     <= 1'b0;
    end else begin
      isr_q       <= (isr_q & ~isr_clr) | isr_set;
      irr_clear_q <= isr_set;
      if (ack_take) begin
        // Nothing eligible at the acknowledge: report IR7, touch nothing.
        level_q    <= req_valid ? req_level : LEVEL_W'(7);
        spurious_q <= ~req_valid;
      end
      if (vec_drive) begin
        data_out_q <= make_vector(vector_base, level_q);
        drive_q    <= 1'b1;
      end else if (ack_done) begin
        drive_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    int_out   = (state_q == ST_REQ);
    data_oe   = drive_q;
    irr_clear = irr_clear_q;
    isr       = isr_q;
    data_out  = data_out_q;
    state_dbg = state_q;
  end

endmodule
